// File: rtl/vga_source_ctrl.sv
// vga_source_ctrl
//   Glitch-free swap between two VGA timing sources (src0 = in-house
//   generator, src1 = known-good generator) driving the board VGA pins.
//   The raw selector is synchronised and debounced. The swap waits for a
//   frame edge of the outgoing source, or gives up after a timeout. The
//   incoming source is then forced to black for BLANK_FRAMES frames so the
//   monitor can re-lock.
//
// Ports
//   clk                 system clock, all logic on posedge
//   rst                 synchronous, active-high reset
//   sel_req             raw selector switch (asynchronous)
//   src0_* / src1_*     12-bit {r,g,b}, display enable, hsync, vsync per source
//   vga_rgb             registered pixel; 0 outside de or while blanking
//   h_sync / v_sync     registered syncs of the active source
//   sel_active          source currently routed (0 = src0)
//   busy                1 while waiting for a frame edge or blanking
//   led                 mirrors sel_active
//   frame_cnt           (only with VGA_SRC_CTRL_FRAME_CNT_EN) frames seen on
//                       the active source since reset or the last swap
//
// Build option
//   VGA_SRC_CTRL_FRAME_CNT_EN : adds the frame_cnt output and its counter.

module vga_source_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BLANK_FRAMES    = 2,
  parameter int unsigned WAIT_TIMEOUT    = 1000000,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_req,
  input  logic [11:0] src0_rgb,
  input  logic        src0_de,
  input  logic        src0_hsync,
  input  logic        src0_vsync,
  input  logic [11:0] src1_rgb,
  input  logic        src1_de,
  input  logic        src1_hsync,
  input  logic        src1_vsync,
  output logic [11:0] vga_rgb,
  output logic        h_sync,
  output logic        v_sync,
  output logic        sel_active,
  output logic        busy,
  output logic        led
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);
  localparam logic [3:0]      FR_LAST = 4'(BLANK_FRAMES - 1);
  localparam logic [3:0]      FR_DONE = 4'(BLANK_FRAMES);

  // Asserted and idle levels of both sync lines.
  localparam logic SYNC_ASSERT = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_IDLE   = ~SYNC_ASSERT;

  typedef enum logic [1:0] {
    S_RUN,
    S_DEBOUNCE,
    S_WAIT_FRAME,
    S_BLANK
  } state_t;

  state_t          r_state;
  logic            r_sel_meta;
  logic            r_sel_sync;
  logic            r_sel_active;
  logic            r_busy;
  logic [DB_W-1:0] r_db_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [3:0]      r_fr_cnt;

  logic            r_vs0;
  logic            r_vs0_d;
  logic            r_vs1;
  logic            r_vs1_d;

  logic [11:0]     r_rgb;
  logic            r_hs;
  logic            r_vs;

  logic            w_edge0;
  logic            w_edge1;
  logic            w_edge_act;
  logic            w_swap;
  logic [11:0]     w_src_rgb;
  logic            w_src_de;
  logic            w_src_hs;
  logic            w_src_vs;

  // ---------------------------------------------------------------------
  // Selector synchroniser and vsync edge pipelines
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written only with <=, so every flop in a block
  // samples the pre-edge value of its neighbours (the two-flop chain relies
  // on this).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_meta <= 1'b0;
      r_sel_sync <= 1'b0;
      r_vs0      <= SYNC_IDLE;
      r_vs0_d    <= SYNC_IDLE;
      r_vs1      <= SYNC_IDLE;
      r_vs1_d    <= SYNC_IDLE;
    end else begin
      r_sel_meta <= sel_req;
      r_sel_sync <= r_sel_meta;
      r_vs0      <= src0_vsync;
      r_vs0_d    <= r_vs0;
      r_vs1      <= src1_vsync;
      r_vs1_d    <= r_vs1;
    end
  end

  // Frame edge: idle -> asserted, seen one cycle after the flop captured it.
  assign w_edge0 = (r_vs0 == SYNC_ASSERT) && (r_vs0_d != SYNC_ASSERT);
  assign w_edge1 = (r_vs1 == SYNC_ASSERT) && (r_vs1_d != SYNC_ASSERT);

  // Edge of whichever source is routed: the old one in WAIT_FRAME, the new
  // one in BLANK (sel_active has already toggled by then).
  assign w_edge_act = r_sel_active ? w_edge1 : w_edge0;

  // A coincident edge and timeout still produce a single toggle.
  assign w_swap = (r_state == S_WAIT_FRAME) && (w_edge_act || (r_to_cnt == TO_LAST));

  // ---------------------------------------------------------------------
  // Swap sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_sel_active <= 1'b0;
      r_busy       <= 1'b0;
      r_db_cnt     <= '0;
      r_to_cnt     <= '0;
      r_fr_cnt     <= '0;
    end else begin
      // NOTE: every branch assigns only the registers it changes; the rest
      // hold their value, which is well defined in a clocked block (no latch).
      unique case (r_state)
        S_RUN: begin
          if (r_sel_sync != r_sel_active) begin
            r_state  <= S_DEBOUNCE;
            r_db_cnt <= '0;
          end
        end

        S_DEBOUNCE: begin
          if (r_sel_sync == r_sel_active) begin
            r_state  <= S_RUN;
            r_db_cnt <= '0;
          end else if (r_db_cnt == DB_LAST) begin
            r_state  <= S_WAIT_FRAME;
            r_to_cnt <= '0;
            r_busy   <= 1'b1;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end

        S_WAIT_FRAME: begin
          if (w_swap) begin
            r_sel_active <= ~r_sel_active;
            r_state      <= S_BLANK;
            r_fr_cnt     <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_BLANK: begin
          if (w_edge_act) begin
            if (r_fr_cnt == FR_LAST) begin
              r_fr_cnt <= FR_DONE;
              r_state  <= S_RUN;
              r_busy   <= 1'b0;
            end else begin
              r_fr_cnt <= r_fr_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registered output mux
  // ---------------------------------------------------------------------
  assign w_src_rgb = r_sel_active ? src1_rgb   : src0_rgb;
  assign w_src_de  = r_sel_active ? src1_de    : src0_de;
  assign w_src_hs  = r_sel_active ? src1_hsync : src0_hsync;
  assign w_src_vs  = r_sel_active ? src1_vsync : src0_vsync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= '0;
      r_hs  <= SYNC_IDLE;
      r_vs  <= SYNC_IDLE;
    end else begin
      r_rgb <= (w_src_de && (r_state != S_BLANK)) ? w_src_rgb : 12'h000;
      r_hs  <= w_src_hs;
      r_vs  <= w_src_vs;
    end
  end

  assign vga_rgb    = r_rgb;
  assign h_sync     = r_hs;
  assign v_sync     = r_vs;
  assign sel_active = r_sel_active;
  assign busy       = r_busy;
  assign led        = r_sel_active;

`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // The swap clears the count even when it is triggered by a frame edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_swap) begin
      r_frame_cnt <= '0;
    end else if (w_edge_act) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_source_ctrl.sv
// tb_vga_source_ctrl
//   Directed bench for vga_source_ctrl with DEBOUNCE_CYCLES = 8,
//   BLANK_FRAMES = 2, WAIT_TIMEOUT = 64, active-low syncs. Inputs change 1 ns
//   after a rising edge and outputs are sampled at the same point, so every
//   expected value is the state just after the preceding edge.

module tb_vga_source_ctrl;

  logic        clk;
  logic        rst;
  logic        sel_req;
  logic [11:0] src0_rgb;
  logic        src0_de;
  logic        src0_hsync;
  logic        src0_vsync;
  logic [11:0] src1_rgb;
  logic        src1_de;
  logic        src1_hsync;
  logic        src1_vsync;
  logic [11:0] vga_rgb;
  logic        h_sync;
  logic        v_sync;
  logic        sel_active;
  logic        busy;
  logic        led;
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  vga_source_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .BLANK_FRAMES    (2),
    .WAIT_TIMEOUT    (64),
    .SYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_req    (sel_req),
    .src0_rgb   (src0_rgb),
    .src0_de    (src0_de),
    .src0_hsync (src0_hsync),
    .src0_vsync (src0_vsync),
    .src1_rgb   (src1_rgb),
    .src1_de    (src1_de),
    .src1_hsync (src1_hsync),
    .src1_vsync (src1_vsync),
    .vga_rgb    (vga_rgb),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .sel_active (sel_active),
    .busy       (busy),
    .led        (led)
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence is ever broken.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required end within 200 us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame on a source: vsync low for two cycles, then idle two cycles.
  // The DUT sees the edge on the second tick.
  task automatic vs_pulse(input bit which);
    if (which) src1_vsync = 1'b0; else src0_vsync = 1'b0;
    tick();
    tick();
    if (which) src1_vsync = 1'b1; else src0_vsync = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    sel_req    = 1'b0;
    src0_rgb   = 12'hFFF;
    src0_de    = 1'b1;
    src0_hsync = 1'b0;
    src0_vsync = 1'b1;
    src1_rgb   = 12'hA5C;
    src1_de    = 1'b1;
    src1_hsync = 1'b1;
    src1_vsync = 1'b1;

    // ---------------- reset ----------------
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rgb",  16'(vga_rgb),    16'h000);
      check("rst_hs",   16'(h_sync),     16'h1);
      check("rst_vs",   16'(v_sync),     16'h1);
      check("rst_sel",  16'(sel_active), 16'h0);
      check("rst_busy", 16'(busy),       16'h0);
      check("rst_led",  16'(led),        16'h0);
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
      check("rst_fcnt", frame_cnt,       16'h0);
`endif
    end
    rst = 1'b0;
    #1;
    check("release_hold_rgb", 16'(vga_rgb), 16'h000);
    tick();
    check("release_rgb", 16'(vga_rgb), 16'hFFF);
    check("release_hs",  16'(h_sync),  16'h0);
    check("release_vs",  16'(v_sync),  16'h1);

    // Display enable gates the pixel.
    src0_de = 1'b0;
    tick();
    check("de_low_rgb", 16'(vga_rgb), 16'h000);
    src0_de = 1'b1;
    tick();
    check("de_high_rgb", 16'(vga_rgb), 16'hFFF);

    // Three src0 frames; v_sync follows src0 one cycle late.
    src0_vsync = 1'b0;
    tick();
    check("vs_follow", 16'(v_sync), 16'h0);
    tick();
    src0_vsync = 1'b1;
    tick();
    tick();
    vs_pulse(1'b0);
    vs_pulse(1'b0);
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
    check("fcnt_src0_3", frame_cnt, 16'd3);
`endif

    // ---------------- glitch rejection ----------------
    sel_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("glitch_busy_hi", 16'(busy), 16'h0);
    end
    sel_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_busy_lo", 16'(busy), 16'h0);
    end
    check("glitch_sel", 16'(sel_active), 16'h0);
    check("glitch_led", 16'(led),        16'h0);
    check("glitch_rgb", 16'(vga_rgb),    16'hFFF);

    // ---------------- clean swap to src1 ----------------
    // 2 sync flops + RUN->DEBOUNCE + 8 debounce cycles = busy after 11 edges.
    sel_req = 1'b1;
    repeat (10) tick();
    check("swap_busy_pre", 16'(busy), 16'h0);
    tick();
    check("swap_busy_rise", 16'(busy), 16'h1);
    repeat (5) tick();
    check("wait_sel_old", 16'(sel_active), 16'h0);
    check("wait_rgb_old", 16'(vga_rgb),    16'hFFF);
    check("wait_busy",    16'(busy),       16'h1);

    src0_vsync = 1'b0;
    tick();
    check("edge_sel_old", 16'(sel_active), 16'h0);
    check("edge_vs_old",  16'(v_sync),     16'h0);
    tick();
    check("swap_sel",  16'(sel_active), 16'h1);
    check("swap_led",  16'(led),        16'h1);
    check("swap_busy", 16'(busy),       16'h1);
    src0_vsync = 1'b1;
    tick();
    check("blank_rgb", 16'(vga_rgb), 16'h000);
    check("blank_hs",  16'(h_sync),  16'h1);
    check("blank_vs",  16'(v_sync),  16'h1);
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
    check("fcnt_cleared", frame_cnt, 16'd0);
`endif

    // First src1 frame: still blanking.
    vs_pulse(1'b1);
    check("blank1_rgb",  16'(vga_rgb), 16'h000);
    check("blank1_busy", 16'(busy),    16'h1);

    // Second src1 frame ends the blank on its edge.
    src1_vsync = 1'b0;
    tick();
    check("blank2_busy", 16'(busy),    16'h1);
    check("blank2_rgb",  16'(vga_rgb), 16'h000);
    tick();
    check("blank_end_busy", 16'(busy),    16'h0);
    check("blank_end_rgb",  16'(vga_rgb), 16'h000);
    src1_vsync = 1'b1;
    tick();
    check("src1_rgb", 16'(vga_rgb),    16'hA5C);
    check("src1_sel", 16'(sel_active), 16'h1);
`ifdef VGA_SRC_CTRL_FRAME_CNT_EN
    check("fcnt_src1_2", frame_cnt, 16'd2);
`endif

    // ---------------- reset from src1, then timeout swap ----------------
    rst = 1'b1;
    tick();
    check("rst2_sel",  16'(sel_active), 16'h0);
    check("rst2_led",  16'(led),        16'h0);
    check("rst2_busy", 16'(busy),       16'h0);
    check("rst2_rgb",  16'(vga_rgb),    16'h000);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("to_busy_pre", 16'(busy), 16'h1 ^ 16'h1);
    tick();
    check("to_busy_rise", 16'(busy), 16'h1);
    repeat (63) tick();
    check("to_sel_pre",  16'(sel_active), 16'h0);
    check("to_busy_hld", 16'(busy),       16'h1);
    check("to_rgb_old",  16'(vga_rgb),    16'hFFF);
    tick();
    check("to_sel_swap", 16'(sel_active), 16'h1);
    check("to_busy",     16'(busy),       16'h1);

    // ---------------- reset in the middle of BLANK ----------------
    rst = 1'b1;
    tick();
    check("midrst_sel",  16'(sel_active), 16'h0);
    check("midrst_busy", 16'(busy),       16'h0);
    check("midrst_rgb",  16'(vga_rgb),    16'h000);
    check("midrst_hs",   16'(h_sync),     16'h1);
    rst = 1'b0;

    // ---------------- late reversal ----------------
    repeat (10) tick();
    check("rev_busy_pre", 16'(busy), 16'h0);
    tick();
    check("rev_busy_rise", 16'(busy), 16'h1);
    src0_vsync = 1'b0;
    tick();
    tick();
    check("rev_swap_sel", 16'(sel_active), 16'h1);
    src0_vsync = 1'b1;
    sel_req    = 1'b0;   // reversed while blanking: must be ignored here
    vs_pulse(1'b1);
    check("rev_blank_busy", 16'(busy),       16'h1);
    check("rev_blank_sel",  16'(sel_active), 16'h1);
    src1_vsync = 1'b0;
    tick();
    tick();
    check("rev_blank_end", 16'(busy), 16'h0);
    src1_vsync = 1'b1;
    // RUN sees the reversed request, then a full 8-cycle debounce.
    repeat (8) tick();
    check("rev_db_busy", 16'(busy),       16'h0);
    check("rev_db_sel",  16'(sel_active), 16'h1);
    tick();
    check("rev_wait_busy", 16'(busy), 16'h1);
    src1_vsync = 1'b0;
    tick();
    check("rev_edge_sel_old", 16'(sel_active), 16'h1);
    tick();
    check("rev_back_sel", 16'(sel_active), 16'h0);
    check("rev_back_led", 16'(led),        16'h0);
    src1_vsync = 1'b1;
    vs_pulse(1'b0);
    vs_pulse(1'b0);
    check("rev_done_busy", 16'(busy),    16'h0);
    check("rev_done_rgb",  16'(vga_rgb), 16'hFFF);
    check("rev_done_hs",   16'(h_sync),  16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
